// File: rtl/pulse_decoder_2x4_pkg.sv
// Shared definitions for the pulse decoder: state encodings, default pulse length
// and the FSM state type used by the top level.
`ifndef DECODER_DEFS_SV
`define DECODER_DEFS_SV
`define DEC_IDLE   2'd0
`define DEC_ACTIVE 2'd1
`define DEC_GAP    2'd2
`endif

package pulse_decoder_2x4_pkg;

  localparam int DEF_PULSE_LEN = 4;
  localparam int DEF_CNT_W     = 3;
  localparam int DEF_ACC_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = `DEC_IDLE,
    ST_ACTIVE = `DEC_ACTIVE,
    ST_GAP    = `DEC_GAP
  } dec_state_e;

  // Counter load for a given pulse length; a zero length degrades to one cycle.
  function automatic int cnt_load(input int pulse_len);
    return (pulse_len < 1) ? 0 : pulse_len - 1;
  endfunction

endpackage

// File: rtl/pulse_decoder_2x4_dec.sv
// Combinational 2-to-4 one-hot decoder with enable; output is all-zero when disabled.
module dec_2x4 (
  input  logic [1:0] code,
  input  logic       en,
  output logic [3:0] line
);

  always_comb begin
    line = '0;
    if (en) line[code] = 1'b1;
  end

endmodule

// File: rtl/pulse_decoder_2x4.sv
// Registered 2-to-4 decoder: accepts a code via valid/ready, holds the decoded line
// high for PULSE_LEN cycles, then spends one gap cycle strobing done.
module pulse_decoder_2x4
  import pulse_decoder_2x4_pkg::*;
#(
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int ACC_W     = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       code_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [3:0]       line_out,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc_count
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(cnt_load(PULSE_LEN));

  dec_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       code_q;
  logic             accept;
  logic [1:0]       dec_code;
  logic             dec_en;
  logic [3:0]       dec_line;

  assign ready_out = (state == ST_IDLE);
  assign accept    = ready_out && valid_in;

  // On the accept edge decode the live input; afterwards keep decoding the captured code.
  assign dec_code = (state == ST_IDLE) ? code_in : code_q;
  assign dec_en   = accept || (state == ST_ACTIVE);

  dec_2x4 u_dec (
    .code (dec_code),
    .en   (dec_en),
    .line (dec_line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      code_q    <= '0;
      line_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      acc_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (valid_in) begin
            state     <= ST_ACTIVE;
            code_q    <= code_in;
            cnt       <= CNT_LOAD;
            line_out  <= dec_line;
            busy      <= 1'b1;
            acc_count <= acc_count + ACC_W'(1);
          end else begin
            line_out <= '0;
            busy     <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (cnt == '0) begin
            state    <= ST_GAP;
            line_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            cnt      <= cnt - CNT_W'(1);
            line_out <= dec_line;
            busy     <= 1'b1;
          end
        end
        ST_GAP: begin
          state    <= ST_IDLE;
          line_out <= '0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          line_out <= '0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_decoder_2x4.sv
// Directed bench for pulse_decoder_2x4: default instance (PULSE_LEN=4) plus a
// PULSE_LEN=1 / ACC_W=2 instance for counter wrap.
module tb_pulse_decoder_2x4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] code_in, code2;
  logic       valid_in, valid2;
  logic       ready_out, busy, done;
  logic [3:0] line_out;
  logic [7:0] acc_count;
  logic       ready2, busy2, done2;
  logic [3:0] line2;
  logic [1:0] acc2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pulse_decoder_2x4 #(.PULSE_LEN(4), .CNT_W(3), .ACC_W(8)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .valid_in(valid_in),
    .ready_out(ready_out), .line_out(line_out), .busy(busy), .done(done),
    .acc_count(acc_count)
  );

  pulse_decoder_2x4 #(.PULSE_LEN(1), .CNT_W(3), .ACC_W(2)) dut2 (
    .clk(clk), .rst(rst), .code_in(code2), .valid_in(valid2),
    .ready_out(ready2), .line_out(line2), .busy(busy2), .done(done2),
    .acc_count(acc2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  int pulses, dones, bad;
  logic [3:0] prev_line;
  logic [1:0] exp_acc2;

  initial begin
    rst = 1'b1; code_in = 2'b00; valid_in = 1'b0; code2 = 2'b00; valid2 = 1'b0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    chk("rst_line", 32'(line_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_acc", 32'(acc_count), 32'h0);
    chk("rst_ready", 32'(ready_out), 32'h1);
    chk("rst2_ready", 32'(ready2), 32'h1);

    // Accept every code, one-cycle valid each
    for (int c = 0; c < 4; c++) begin
      code_in = 2'(c); valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
        chk("all_line", 32'(line_out), 32'(4'b0001 << c));
        chk("all_busy", 32'(busy), 32'h1);
        chk("all_ready", 32'(ready_out), 32'h0);
        tick();
      end
      chk("all_gap_line", 32'(line_out), 32'h0);
      chk("all_gap_done", 32'(done), 32'h1);
      chk("all_gap_ready", 32'(ready_out), 32'h0);
      tick();
      chk("all_idle_done", 32'(done), 32'h0);
      chk("all_idle_ready", 32'(ready_out), 32'h1);
    end
    chk("all_acc", 32'(acc_count), 32'd4);

    // Input change mid-pulse is ignored; next accept is 6 edges later
    code_in = 2'b10; valid_in = 1'b1;
    tick();
    code_in = 2'b01;
    for (int k = 0; k < 4; k++) begin
      chk("mid_line", 32'(line_out), 32'h4);
      tick();
    end
    chk("mid_gap_done", 32'(done), 32'h1);
    tick();
    chk("mid_idle_ready", 32'(ready_out), 32'h1);
    chk("mid_idle_line", 32'(line_out), 32'h0);
    tick();
    valid_in = 1'b0;
    chk("mid_second_line", 32'(line_out), 32'h2);
    chk("mid_acc", 32'(acc_count), 32'd6);
    for (int k = 0; k < 5; k++) tick();
    chk("mid_drain_ready", 32'(ready_out), 32'h1);

    // Back-to-back with valid held high for 18 cycles
    rst = 1'b1; tick(); rst = 1'b0;
    code_in = 2'b11; valid_in = 1'b1;
    pulses = 0; dones = 0; bad = 0; prev_line = 4'h0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (line_out == 4'h8 && prev_line == 4'h0) pulses++;
      if (done) dones++;
      if ((line_out != 4'h0 && line_out != 4'h8) || (done && busy) || (busy != (line_out != 4'h0)))
        bad++;
      prev_line = line_out;
    end
    valid_in = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd3);
    chk("b2b_dones", 32'(dones), 32'd3);
    chk("b2b_invariants", 32'(bad), 32'd0);
    chk("b2b_acc", 32'(acc_count), 32'd3);
    tick();

    // Reset on the second ACTIVE cycle
    code_in = 2'b01; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    chk("rmid_line_before", 32'(line_out), 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid_line", 32'(line_out), 32'h0);
    chk("rmid_done", 32'(done), 32'h0);
    chk("rmid_acc", 32'(acc_count), 32'h0);
    chk("rmid_ready", 32'(ready_out), 32'h1);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dones++;
    end
    chk("rmid_no_done", 32'(dones), 32'd0);

    // PULSE_LEN=1, ACC_W=2: period 3, acc wraps 1,2,3,0,1
    exp_acc2 = 2'd1;
    for (int i = 0; i < 5; i++) begin
      code2 = 2'(i); valid2 = 1'b1;
      tick();
      valid2 = 1'b0;
      chk("wrap_line", 32'(line2), 32'(4'b0001 << (i % 4)));
      chk("wrap_acc", 32'(acc2), 32'(exp_acc2));
      tick();
      chk("wrap_gap_line", 32'(line2), 32'h0);
      chk("wrap_gap_done", 32'(done2), 32'h1);
      tick();
      chk("wrap_idle_ready", 32'(ready2), 32'h1);
      exp_acc2 = exp_acc2 + 2'd1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends on its own
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
